// File: rtl/lcd_responder.sv
// HD44780-style bus responder: 80-byte DDRAM, control decode, busy timing. Strobe acted on 3 clk after en falls; rd_data 1 clk.
// No backpressure on the bus: a strobe arriving while busy is dropped and flagged in err.
module lcd_responder #(
    parameter int CLR_CYC  = 8,
    parameter int BUSY_CYC = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rs,
    input  logic       rw,
    input  logic       en,
    input  logic [7:0] din,
    input  logic [6:0] rd_addr,
    output logic [7:0] rd_data,
    output logic [7:0] status,
    output logic       disp_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic       font5x10,
    output logic       dl8,
    output logic       wr_pulse,
    output logic       err
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WAIT} state_t;

    state_t      r_state;
    logic [15:0] r_cnt;
    logic        r_en_s1, r_en_s2, r_en_d;
    logic        r_rs_s1, r_rs_s2, r_rw_s1, r_rw_s2;
    logic [7:0]  r_din_s1, r_din_s2;
    logic        r_lat_rs, r_lat_rw;
    logic [7:0]  r_lat_din;
    logic [6:0]  r_ac;
    logic        r_id, r_disp, r_cur, r_blink, r_two, r_font, r_dl8, r_wr, r_err;
    logic [79:0] r_wmask;
    logic [7:0]  r_mem [0:79];
    logic [7:0]  r_rd;

    function automatic logic addr_ok(input logic [6:0] a, input logic two);
        if (two) return (a <= 7'h27) || (a >= 7'h40 && a <= 7'h67);
        return a <= 7'h4F;
    endfunction

    // Second line of a two-line display lives right after the first 40 bytes.
    function automatic logic [6:0] addr_idx(input logic [6:0] a, input logic two);
        if (two && a[6]) return 7'd40 + {1'b0, a[5:0]};
        return a;
    endfunction

    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic two, input logic up);
        if (two) begin
            if (up) return (a == 7'h27) ? 7'h40 : (a == 7'h67) ? 7'h00 : a + 7'd1;
            return (a == 7'h00) ? 7'h67 : (a == 7'h40) ? 7'h27 : a - 7'd1;
        end
        if (up) return (a == 7'h4F) ? 7'h00 : a + 7'd1;
        return (a == 7'h00) ? 7'h4F : a - 7'd1;
    endfunction

    logic       w_strobe, w_accept, w_mem_we;
    logic [6:0] w_wr_idx, w_rd_idx;

    assign w_strobe = r_en_d & ~r_en_s2;
    assign w_accept = w_strobe && (r_state == S_IDLE) && !r_lat_rw && (r_lat_rs || (r_lat_din != 8'h00));
    assign w_wr_idx = addr_idx(r_ac, r_two);
    assign w_rd_idx = addr_idx(rd_addr, r_two);
    assign w_mem_we = w_accept && r_lat_rs && addr_ok(r_ac, r_two);

    always_ff @(posedge clk) begin
        if (w_mem_we) r_mem[w_wr_idx] <= r_lat_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;   r_cnt <= 16'd0;
            r_en_s1 <= 1'b0;     r_en_s2 <= 1'b0;   r_en_d <= 1'b0;
            r_rs_s1 <= 1'b0;     r_rs_s2 <= 1'b0;
            r_rw_s1 <= 1'b0;     r_rw_s2 <= 1'b0;
            r_din_s1 <= 8'h00;   r_din_s2 <= 8'h00;
            r_lat_rs <= 1'b0;    r_lat_rw <= 1'b0;  r_lat_din <= 8'h00;
            r_ac <= 7'h00;       r_id <= 1'b1;
            r_disp <= 1'b0;      r_cur <= 1'b0;     r_blink <= 1'b0;
            r_two <= 1'b0;       r_font <= 1'b0;    r_dl8 <= 1'b1;
            r_wr <= 1'b0;        r_err <= 1'b0;
            r_wmask <= '0;       r_rd <= 8'h20;
        end else begin
            r_en_s1  <= en;       r_en_s2  <= r_en_s1;  r_en_d <= r_en_s2;
            r_rs_s1  <= rs;       r_rs_s2  <= r_rs_s1;
            r_rw_s1  <= rw;       r_rw_s2  <= r_rw_s1;
            r_din_s1 <= din;      r_din_s2 <= r_din_s1;
            if (r_en_s2) begin
                r_lat_rs <= r_rs_s2; r_lat_rw <= r_rw_s2; r_lat_din <= r_din_s2;
            end
            r_rd <= (addr_ok(rd_addr, r_two) && r_wmask[w_rd_idx]) ? r_mem[w_rd_idx] : 8'h20;
            r_wr <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state <= S_EXEC;
                        r_cnt   <= BUSY_CYC[15:0];
                        if (r_lat_rs) begin
                            r_wr <= 1'b1;
                            r_wmask[w_wr_idx] <= 1'b1;
                            r_ac <= addr_step(r_ac, r_two, r_id);
                        end else begin
                            casez (r_lat_din)
                                8'b1???????: begin
                                    if (addr_ok(r_lat_din[6:0], r_two)) r_ac <= r_lat_din[6:0];
                                    else r_err <= 1'b1;
                                end
                                8'b01??????: ;
                                8'b001?????: begin
                                    r_dl8 <= r_lat_din[4]; r_two <= r_lat_din[3]; r_font <= r_lat_din[2];
                                    if (!addr_ok(r_ac, r_lat_din[3])) r_ac <= 7'h00;
                                end
                                8'b0001????: begin
                                    if (!r_lat_din[3]) r_ac <= addr_step(r_ac, r_two, r_lat_din[2]);
                                end
                                8'b00001???: begin
                                    r_disp <= r_lat_din[2]; r_cur <= r_lat_din[1]; r_blink <= r_lat_din[0];
                                end
                                8'b000001??: r_id <= r_lat_din[1];
                                8'b0000001?: begin
                                    r_ac <= 7'h00; r_cnt <= CLR_CYC[15:0];
                                end
                                8'b00000001: begin
                                    r_ac <= 7'h00; r_id <= 1'b1; r_wmask <= '0; r_cnt <= CLR_CYC[15:0];
                                end
                                default: ;
                            endcase
                        end
                    end
                end
                S_EXEC, S_WAIT: begin
                    if (w_strobe) r_err <= 1'b1;
                    // r_cnt holds the busy cycles still owed, including this one.
                    if (r_cnt <= 16'd1) r_state <= S_IDLE;
                    else begin
                        r_cnt   <= r_cnt - 16'd1;
                        r_state <= S_WAIT;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rd_data   = r_rd;
    assign status    = {r_state != S_IDLE, r_ac};
    assign disp_on   = r_disp;
    assign cursor_on = r_cur;
    assign blink_on  = r_blink;
    assign two_line  = r_two;
    assign font5x10  = r_font;
    assign dl8       = r_dl8;
    assign wr_pulse  = r_wr;
    assign err       = r_err;
endmodule

// File: tb/tb_lcd_responder.sv
// Directed bench for lcd_responder: bus strobes with hand-computed expectations.
module tb_lcd_responder;
    logic       clk = 1'b0;
    logic       rst, rs, rw, en;
    logic [7:0] din;
    logic [6:0] rd_addr;
    logic [7:0] rd_data, status;
    logic       disp_on, cursor_on, blink_on, two_line, font5x10, dl8, wr_pulse, err;

    int n_chk = 0;
    int n_fail = 0;
    int busy_cyc = 0;
    int wr_cnt = 0;

    always #5 clk = ~clk;

    lcd_responder #(.CLR_CYC(8), .BUSY_CYC(2)) dut (
        .clk(clk), .rst(rst), .rs(rs), .rw(rw), .en(en), .din(din),
        .rd_addr(rd_addr), .rd_data(rd_data), .status(status),
        .disp_on(disp_on), .cursor_on(cursor_on), .blink_on(blink_on),
        .two_line(two_line), .font5x10(font5x10), .dl8(dl8),
        .wr_pulse(wr_pulse), .err(err)
    );

    always @(negedge clk) begin
        if (status[7]) busy_cyc <= busy_cyc + 1;
        if (wr_pulse)  wr_cnt   <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic p_rs, input logic p_rw, input logic [7:0] p_d);
        rs = p_rs; rw = p_rw; din = p_d; en = 1'b1;
        tick(3);
        en = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        tick(4);
        k = 0;
        while (status[7] && k < 60) begin
            tick(1);
            k++;
        end
        check(tag, 32'(k < 60), 32'd1);
    endtask

    task automatic wait_busy(input string tag);
        int k;
        k = 0;
        while (!status[7] && k < 20) begin
            tick(1);
            k++;
        end
        check(tag, 32'(k < 20), 32'd1);
    endtask

    task automatic cmd(input logic [7:0] d);
        pulse(1'b0, 1'b0, d);
        wait_idle("cmd_idle");
    endtask

    task automatic dat(input logic [7:0] d);
        pulse(1'b1, 1'b0, d);
        wait_idle("dat_idle");
    endtask

    task automatic rd_check(input string tag, input logic [6:0] a, input logic [7:0] exp);
        rd_addr = a;
        tick(1);
        check(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        int b0, w0;
        rst = 1'b1; rs = 1'b0; rw = 1'b0; en = 1'b0; din = 8'h00; rd_addr = 7'h00;
        tick(3);
        check("rst_status", 32'(status), 32'h00);
        check("rst_rd_data", 32'(rd_data), 32'h20);
        check("rst_ctrl", 32'({disp_on, cursor_on, blink_on, two_line, font5x10, dl8}), 32'b000001);
        check("rst_err_wr", 32'({err, wr_pulse}), 32'b00);
        rst = 1'b0;
        tick(2);

        // Init sequence
        cmd(8'h38); cmd(8'h01); cmd(8'h0E); cmd(8'h06); cmd(8'h80);
        check("init_ctrl", 32'({disp_on, cursor_on, blink_on, two_line, font5x10, dl8}), 32'b110101);
        check("init_status", 32'(status), 32'h00);

        // Data writes
        w0 = wr_cnt;
        dat(8'h76); dat(8'h61); dat(8'h72);
        check("data_ac", 32'(status), 32'h03);
        check("wr_pulses", 32'(wr_cnt - w0), 32'd3);
        rd_check("rd_0", 7'h00, 8'h76);
        rd_check("rd_1", 7'h01, 8'h61);
        rd_check("rd_2", 7'h02, 8'h72);
        rd_check("rd_3_blank", 7'h03, 8'h20);

        // Line wrap, increment then decrement
        cmd(8'hA7);
        check("set_27", 32'(status), 32'h27);
        dat(8'h41);
        check("wrap_inc", 32'(status), 32'h40);
        rd_check("rd_27", 7'h27, 8'h41);
        cmd(8'h80); cmd(8'h04); dat(8'h42);
        check("wrap_dec", 32'(status), 32'h67);
        rd_check("rd_0_new", 7'h00, 8'h42);
        check("no_err_yet", 32'(err), 32'd0);

        // Clear, then a strobe while busy
        b0 = busy_cyc;
        pulse(1'b0, 1'b0, 8'h01);
        wait_busy("clr_busy_rise");
        rs = 1'b0; rw = 1'b0; din = 8'h85; en = 1'b1;
        tick(2);
        en = 1'b0;
        wait_idle("clr_idle");
        check("clr_busy_len", 32'(busy_cyc - b0), 32'd8);
        check("drop_err", 32'(err), 32'd1);
        check("drop_ac", 32'(status), 32'h00);
        rd_check("clr_rd_0", 7'h00, 8'h20);
        rd_check("clr_rd_27", 7'h27, 8'h20);

        // Invalid address and read strobes, from a fresh reset
        rst = 1'b1;
        tick(2);
        check("rst2_err", 32'(err), 32'd0);
        rst = 1'b0;
        tick(1);
        cmd(8'h38); cmd(8'h85);
        check("ac_05", 32'(status), 32'h05);
        cmd(8'hAA);
        check("bad_addr_ac", 32'(status), 32'h05);
        check("bad_addr_err", 32'(err), 32'd1);
        b0 = busy_cyc;
        pulse(1'b0, 1'b1, 8'h01);
        tick(10);
        check("rw_no_busy", 32'(busy_cyc - b0), 32'd0);
        check("rw_status", 32'(status), 32'h05);

        // Reset in the middle of a data write's busy window
        rd_addr = 7'h05;
        pulse(1'b1, 1'b0, 8'h55);
        wait_busy("wr_busy_rise");
        tick(1);
        check("pre_rst_rd", 32'(rd_data), 32'h55);
        check("pre_rst_busy", 32'(status[7]), 32'd1);
        rst = 1'b1;
        tick(1);
        check("rst_mid_status", 32'(status), 32'h00);
        check("rst_mid_rd", 32'(rd_data), 32'h20);
        rst = 1'b0;
        tick(3);
        check("post_rst_rd", 32'(rd_data), 32'h20);
        check("post_rst_status", 32'(status), 32'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
